// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: FSM state encodings, default memory depth, address helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } ld_state_t;

    // Default instruction memory depth in 32-bit words; the memory itself uses the same value.
    localparam int unsigned IMEM_WORDS_DFLT = 8192;

    // Byte address of word number idx in an image that starts at base.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four consecutive bytes into a little-endian word (first byte -> bits 7:0).
// Latency: word_vld/word_dat are combinational in the cycle the 4th byte is offered.
// Backpressure: none; the caller only asserts byte_vld on an accepted transfer.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [1:0]  idx;
    logic [23:0] held;

    // Byte index and the three earlier bytes of the word under construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= 2'd0;
            held <= 24'd0;
        end else if (clr) begin
            idx  <= 2'd0;
            held <= 24'd0;
        end else if (byte_vld) begin
            idx  <= idx + 2'd1;
            held <= {byte_dat, held[23:8]};
        end
    end

    assign word_vld = byte_vld && (idx == 2'd3);
    assign word_dat = {byte_dat, held};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a header/data/checksum byte stream, writes words to imem, releases CPU reset.
// Latency: imem write one cycle after a word's 4th byte; cpu_rst_n rises one cycle after the checksum byte.
// Backpressure: in_ready high only in HDR/DATA/CSUM; sustains 1 byte/clk, stalls freely on in_valid low.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DFLT,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] words_loaded
);

    ld_state_t   state;
    ld_state_t   state_nxt;
    logic [31:0] hdr_count;
    logic [7:0]  sum;
    logic [7:0]  sum_plus;
    logic        accept;
    logic        start_go;
    logic        pack_vld;
    logic        word_vld;
    logic [31:0] word_dat;

    assign busy     = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
    assign in_ready = busy;
    assign done     = (state == ST_DONE);
    assign error    = (state == ST_ERR);
    assign accept   = in_valid && in_ready;
    assign start_go = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign pack_vld = accept && ((state == ST_HDR) || (state == ST_DATA));
    assign sum_plus = sum + in_data;

    imem_loader_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_go),
        .byte_vld (pack_vld),
        .byte_dat (in_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: header decode, word count, checksum verdict.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (word_vld) begin
                    if (word_dat > 32'(IMEM_WORDS)) state_nxt = ST_ERR;
                    else if (word_dat == 32'd0)     state_nxt = ST_CSUM;
                    else                            state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                // The last word's write issues in the cycle after this, with the FSM
                // already in CSUM so the checksum byte can follow back-to-back.
                if (word_vld && ((words_loaded + 32'd1) == hdr_count)) state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                if (accept) state_nxt = (sum_plus == 8'd0) ? ST_DONE : ST_ERR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: running checksum, header count, memory write port, CPU reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum          <= 8'd0;
            hdr_count    <= 32'd0;
            words_loaded <= 32'd0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            cpu_rst_n    <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            cpu_rst_n <= (state_nxt == ST_DONE);
            if (start_go) begin
                sum          <= 8'd0;
                hdr_count    <= 32'd0;
                words_loaded <= 32'd0;
            end else begin
                if (pack_vld) sum <= sum_plus;
                if ((state == ST_HDR) && word_vld) hdr_count <= word_dat;
                if ((state == ST_DATA) && word_vld) begin
                    imem_we      <= 1'b1;
                    imem_addr    <= word_addr(BASE_ADDR, words_loaded);
                    imem_wdata   <= word_dat;
                    words_loaded <= words_loaded + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios plus randomized images against a stream-level model.
// Latency: n/a.
// Backpressure: drives in_valid with random gaps and waits (bounded) on in_ready.
module tb_imem_loader;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned WORDS = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] words_loaded;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stream[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_done;
    logic        exp_err;
    logic [31:0] exp_words;
    int          exp_consume;

    imem_loader #(.IMEM_WORDS(WORDS), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Record every memory write seen by the instruction memory.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_imem_we"},  {31'd0, imem_we},  32'd0);
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_error"},    {31'd0, error},    32'd0);
        check({tag, "_cpu_rst"},  {31'd0, cpu_rst_n}, 32'd0);
        check({tag, "_addr"},     imem_addr,         BASE);
        check({tag, "_wdata"},    imem_wdata,        32'd0);
        check({tag, "_words"},    words_loaded,      32'd0);
    endtask

    // Expected outcome of the image in 'stream', from the format rules alone.
    task automatic model_expect();
        logic [31:0] n;
        int unsigned s;
        exp_addr.delete();
        exp_data.delete();
        n = {stream[3], stream[2], stream[1], stream[0]};
        if (n > WORDS) begin
            exp_err = 1'b1; exp_done = 1'b0; exp_words = 32'd0; exp_consume = 4;
        end else begin
            for (int k = 0; k < int'(n); k++) begin
                exp_addr.push_back(BASE + 32'(4 * k));
                exp_data.push_back({stream[4*k+7], stream[4*k+6], stream[4*k+5], stream[4*k+4]});
            end
            s = 0;
            for (int i = 0; i < 4 * int'(n) + 5; i++) s += stream[i];
            exp_done    = ((s % 256) == 0);
            exp_err     = !exp_done;
            exp_words   = n;
            exp_consume = 4 * int'(n) + 5;
        end
    endtask

    task automatic build_stream(input logic [31:0] n, input bit good);
        int unsigned s;
        logic [7:0] c;
        stream.delete();
        stream.push_back(n[7:0]);   stream.push_back(n[15:8]);
        stream.push_back(n[23:16]); stream.push_back(n[31:24]);
        if (n <= WORDS) begin
            for (int i = 0; i < 4 * int'(n); i++) stream.push_back(8'($urandom_range(0, 255)));
            s = 0;
            foreach (stream[i]) s += stream[i];
            c = 8'((256 - (s % 256)) % 256);
            if (!good) c = c + 8'($urandom_range(1, 255));
            stream.push_back(c);
        end
    endtask

    // Entered and left at posedge+1. Offers one byte after 'gap' idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
            check("stall_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("ready_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
    endtask

    // gap_mode < 0: fixed gap of -gap_mode cycles; otherwise random gap 0..gap_mode.
    task automatic run_load(input string tag, input int gap_mode, input bit do_start);
        int gap;
        model_expect();
        wr_addr_q.delete();
        wr_data_q.delete();
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check({tag, "_busy_on_start"}, {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        for (int i = 0; i < exp_consume; i++) begin
            gap = (gap_mode < 0) ? -gap_mode : int'($urandom_range(0, gap_mode));
            if (i == 0) gap = 0;
            if (i == exp_consume - 1)
                check({tag, "_cpu_rst_before_last"}, {31'd0, cpu_rst_n}, 32'd0);
            send_byte(stream[i], gap);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_cpu_rst_after_last"}, {31'd0, cpu_rst_n}, {31'd0, exp_done});
        check({tag, "_done"},  {31'd0, done},  {31'd0, exp_done});
        check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        // Bytes offered after the load ends must be ignored.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_words"}, words_loaded, exp_words);
        check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size() && k < wr_addr_q.size(); k++) begin
            check({tag, "_wr_addr"}, wr_addr_q[k], exp_addr[k]);
            check({tag, "_wr_data"}, wr_data_q[k], exp_data[k]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state.
        #12;
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", {31'd0, in_ready}, 32'd0);

        // Good two-word image, in_valid held high. Bytes before the checksum sum to 0xB8.
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'h48};
        run_load("good", 0, 1'b1);
        check("good_word0", exp_data[0], 32'h0000_0013);
        check("good_word1", exp_data[1], 32'h0010_0093);

        // Reload from DONE.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("reload_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
        check("reload_busy",    {31'd0, busy},      32'd1);
        check("reload_done",    {31'd0, done},      32'd0);

        // Bad checksum on the same image, continuing the load just started.
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'h49};
        run_load("badsum", 0, 1'b0);

        // Header one word larger than the memory.
        build_stream(WORDS + 1, 1'b1);
        run_load("oversize", 0, 1'b1);

        // Empty image, two idle cycles before every byte after the first.
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_load("empty_gaps", -2, 1'b1);

        // Reset in the middle of DATA, after six data bytes.
        build_stream(32'd3, 1'b1);
        model_expect();
        wr_addr_q.delete();
        wr_data_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) send_byte(stream[i], 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        check("midreset_wr_count", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() > 0) check("midreset_wr_data", wr_data_q[0], exp_data[0]);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        build_stream(32'd2, 1'b1);
        run_load("after_reset", 1, 1'b1);

        // Randomized images with random stalls.
        for (int t = 0; t < 12; t++) begin
            logic [31:0] n;
            n = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) n = WORDS + 1 + 32'($urandom_range(0, 1000));
            build_stream(n, $urandom_range(0, 3) != 0);
            run_load("rand", 2, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
